// File: rtl/icache_pkg.sv
// icache_pkg: shared widths, default geometry and FSM state type for the instruction cache.
package icache_pkg;
  localparam int INSTR_ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam int ICACHE_INDEX_BITS = 7;
  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;
endpackage

// File: rtl/icache_if.sv
// icache_if: IF-stage request/response plus memory-controller fetch bus; slave = cache side.
interface icache_if import icache_pkg::*; #(parameter int ADDR_WIDTH = INSTR_ADDR_W);
  logic instruction_read_flag;
  logic [ADDR_WIDTH-1:0] instruction_read;
  logic instruction_flag;
  logic [INSTR_W-1:0] instruction;
  logic mem_read_flag;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic mem_data_flag;
  logic [INSTR_W-1:0] mem_data;
  modport master(
    output instruction_read_flag, instruction_read, mem_data_flag, mem_data,
    input instruction_flag, instruction, mem_read_flag, mem_addr
  );
  modport slave(
    input instruction_read_flag, instruction_read, mem_data_flag, mem_data,
    output instruction_flag, instruction, mem_read_flag, mem_addr
  );
endinterface

// File: rtl/icache_line_ram.sv
// icache_line_ram: valid/tag/data line arrays; combinational read, one sync write, async valid clear.
module icache_line_ram #(
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS = 23,
  parameter int DATA_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [DATA_BITS-1:0]  rd_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_BITS-1:0]  wr_data
);
  localparam int LINES = 1 << INDEX_BITS;
  logic [LINES-1:0] valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [DATA_BITS-1:0] data [LINES];
  always_ff @(posedge clk or negedge rst)
    if (!rst) valid <= '0;
    else if (we) valid[wr_index] <= 1'b1;
  // tag and data survive reset; only valid bits are cleared
  always_ff @(posedge clk)
    if (we) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  assign rd_valid = valid[rd_index];
  assign rd_tag = tags[rd_index];
  assign rd_data = data[rd_index];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped one-word-per-line I-cache with zero-latency hits and fill forwarding.
// Optional hit/miss counters when ICACHE_PERF_EN is defined.
module icache import icache_pkg::*; #(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int ADDR_WIDTH = INSTR_ADDR_W
) (
  input logic clk,
  input logic rst,
  icache_if.slave bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
  state_t state;
  logic [INSTR_W-1:0] instr_q;
  logic rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [INSTR_W-1:0] rd_data;
  logic hit, fill, fwd, miss;
  icache_line_ram #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS), .DATA_BITS(INSTR_W)) u_ram (
    .clk      (clk),
    .rst      (rst),
    .rd_index (bus.instruction_read[INDEX_BITS+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (fill),
    .wr_index (bus.mem_addr[INDEX_BITS+1:2]),
    .wr_tag   (bus.mem_addr[ADDR_WIDTH-1:INDEX_BITS+2]),
    .wr_data  (bus.mem_data)
  );
  // compare against the pre-write array so a same-cycle fill never turns a request into a hit
  always_comb begin
    hit = bus.instruction_read_flag & rd_valid & (rd_tag == bus.instruction_read[ADDR_WIDTH-1:INDEX_BITS+2]);
    fill = (state == FETCH) & bus.mem_data_flag;
    fwd = fill & bus.instruction_read_flag & (bus.instruction_read[ADDR_WIDTH-1:2] == bus.mem_addr[ADDR_WIDTH-1:2]);
    miss = (state == IDLE) & bus.instruction_read_flag & ~hit;
  end
  assign bus.instruction_flag = hit | fwd;
  assign bus.instruction = hit ? rd_data : fwd ? bus.mem_data : instr_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      bus.mem_read_flag <= 1'b0;
      bus.mem_addr <= '0;
      instr_q <= '0;
    end else begin
      if (bus.instruction_flag) instr_q <= bus.instruction;
      if (miss) begin
        state <= FETCH;
        bus.mem_read_flag <= 1'b1;
        bus.mem_addr <= {bus.instruction_read[ADDR_WIDTH-1:2], 2'b00};
      end else if (fill) begin
        state <= IDLE;
        bus.mem_read_flag <= 1'b0;
      end
    end
`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      hit_count <= hit_count + 32'(hit);
      miss_count <= miss_count + 32'(miss);
    end
`endif
endmodule
